// File: rtl/hpm_ovf_filter.sv
// Sscofpmf privilege-mode filter and overflow tracker for the HPM counter bank.
// Generates per-counter count enables, sticky OF bits, scountovf and LCOFIP.
module hpm_ovf_filter #(
  parameter int unsigned NumCounters = 29
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             priv_lvl_i,
  input  logic                   debug_mode_i,
  input  logic                   csr_we_i,
  input  logic [4:0]             csr_idx_i,
  input  logic [3:0]             csr_wdata_i,
  output logic [3:0]             csr_rdata_o,
  input  logic [NumCounters-1:0] cnt_inc_i,
  input  logic [NumCounters-1:0] cnt_allones_i,
  output logic [NumCounters-1:0] count_en_o,
  output logic [NumCounters-1:0] of_o,
  input  logic [31:0]            mcounteren_i,
  output logic [31:0]            scountovf_o,
  input  logic                   lcofip_set_i,
  input  logic                   lcofip_clr_i,
  output logic                   lcofip_o
);

  logic [NumCounters-1:0] of_q, of_d;
  logic [NumCounters-1:0] minh_q, minh_d;
  logic [NumCounters-1:0] sinh_q, sinh_d;
  logic [NumCounters-1:0] uinh_q, uinh_d;
  logic                   lcofip_q, lcofip_d;

  logic [NumCounters-1:0] wrap;
  logic [NumCounters-1:0] wr_sel;
  logic                   ovf_rise;

  // mcounteren bits 0..2 (cycle/time/instret) have no OF bit to mask.
  logic unused_mcounteren;
  assign unused_mcounteren = ^mcounteren_i[2:0];

  // Out-of-range indices never match any wr_sel bit, so such writes are dropped.
  always_comb begin
    wrap     = cnt_inc_i & cnt_allones_i;
    ovf_rise = |(wrap & ~of_q);
    wr_sel   = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      wr_sel[k] = csr_we_i && (csr_idx_i == 5'(k));
    end
  end

  always_comb begin
    of_d   = of_q;
    minh_d = minh_q;
    sinh_d = sinh_q;
    uinh_d = uinh_q;
    for (int k = 0; k < int'(NumCounters); k++) begin
      if (wr_sel[k]) begin
        of_d[k]   = csr_wdata_i[3];
        minh_d[k] = csr_wdata_i[2];
        sinh_d[k] = csr_wdata_i[1];
        uinh_d[k] = csr_wdata_i[0];
      end
      if (wrap[k]) begin
        of_d[k] = 1'b1;
      end
    end
    lcofip_d = ovf_rise | lcofip_set_i | (lcofip_q & ~lcofip_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_q     <= '0;
      minh_q   <= '0;
      sinh_q   <= '0;
      uinh_q   <= '0;
      lcofip_q <= 1'b0;
    end else begin
      of_q     <= of_d;
      minh_q   <= minh_d;
      sinh_q   <= sinh_d;
      uinh_q   <= uinh_d;
      lcofip_q <= lcofip_d;
    end
  end

  // Reserved privilege 2 matches no inhibit term; only debug mode gates it.
  always_comb begin
    count_en_o = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      count_en_o[k] = ~debug_mode_i
                    & ~((priv_lvl_i == 2'd3) & minh_q[k])
                    & ~((priv_lvl_i == 2'd1) & sinh_q[k])
                    & ~((priv_lvl_i == 2'd0) & uinh_q[k]);
    end
  end

  always_comb begin
    csr_rdata_o = 4'b0000;
    scountovf_o = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      if (csr_idx_i == 5'(k)) begin
        csr_rdata_o = {of_q[k], minh_q[k], sinh_q[k], uinh_q[k]};
      end
      scountovf_o[k+3] = of_q[k] & mcounteren_i[k+3];
    end
  end

  assign of_o     = of_q;
  assign lcofip_o = lcofip_q;

endmodule

// File: tb/tb_hpm_ovf_filter.sv
// Self-checking bench for hpm_ovf_filter: directed scenarios plus randomized
// traffic compared against a behavioural model of the OF/mode/LCOFIP rules.
module tb_hpm_ovf_filter;

  localparam int N = 29;

  logic          clk_i;
  logic          rst_ni;
  logic [1:0]    priv_lvl_i;
  logic          debug_mode_i;
  logic          csr_we_i;
  logic [4:0]    csr_idx_i;
  logic [3:0]    csr_wdata_i;
  logic [3:0]    csr_rdata_o;
  logic [N-1:0]  cnt_inc_i;
  logic [N-1:0]  cnt_allones_i;
  logic [N-1:0]  count_en_o;
  logic [N-1:0]  of_o;
  logic [31:0]   mcounteren_i;
  logic [31:0]   scountovf_o;
  logic          lcofip_set_i;
  logic          lcofip_clr_i;
  logic          lcofip_o;

  int checks;
  int errors;

  // Reference model state: one OF flag and one 3-bit {M,S,U} inhibit mask per counter.
  bit [N-1:0] m_of;
  bit [2:0]   m_mode [N];
  bit         m_lcofip;

  hpm_ovf_filter #(.NumCounters(N)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .priv_lvl_i    (priv_lvl_i),
    .debug_mode_i  (debug_mode_i),
    .csr_we_i      (csr_we_i),
    .csr_idx_i     (csr_idx_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .cnt_inc_i     (cnt_inc_i),
    .cnt_allones_i (cnt_allones_i),
    .count_en_o    (count_en_o),
    .of_o          (of_o),
    .mcounteren_i  (mcounteren_i),
    .scountovf_o   (scountovf_o),
    .lcofip_set_i  (lcofip_set_i),
    .lcofip_clr_i  (lcofip_clr_i),
    .lcofip_o      (lcofip_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] exp_count_en();
    logic [N-1:0] en;
    for (int k = 0; k < N; k++) begin
      if (debug_mode_i)          en[k] = 1'b0;
      else if (priv_lvl_i == 3)  en[k] = ~m_mode[k][2];
      else if (priv_lvl_i == 1)  en[k] = ~m_mode[k][1];
      else if (priv_lvl_i == 0)  en[k] = ~m_mode[k][0];
      else                       en[k] = 1'b1;
    end
    return en;
  endfunction

  function automatic logic [3:0] exp_rdata();
    int i;
    i = int'(csr_idx_i);
    if (i < N) return {m_of[i], m_mode[i]};
    return 4'b0000;
  endfunction

  function automatic logic [31:0] exp_scountovf();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k+3] = m_of[k] & mcounteren_i[k+3];
    return v;
  endfunction

  task automatic model_reset();
    m_of = '0;
    m_lcofip = 1'b0;
    for (int k = 0; k < N; k++) m_mode[k] = 3'b000;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    bit [N-1:0] nof;
    bit [2:0]   nmode [N];
    bit         rise;
    bit         w;
    rise = 1'b0;
    for (int k = 0; k < N; k++) begin
      w = cnt_inc_i[k] & cnt_allones_i[k];
      nmode[k] = m_mode[k];
      nof[k] = m_of[k];
      if (csr_we_i && int'(csr_idx_i) == k) begin
        nof[k] = csr_wdata_i[3];
        nmode[k] = csr_wdata_i[2:0];
      end
      if (w) begin
        if (!m_of[k]) rise = 1'b1;
        nof[k] = 1'b1;
      end
    end
    @(posedge clk_i);
    m_lcofip = rise | lcofip_set_i | (m_lcofip & ~lcofip_clr_i);
    m_of = nof;
    for (int k = 0; k < N; k++) m_mode[k] = nmode[k];
    #1;
  endtask

  task automatic idle();
    csr_we_i = 1'b0;
    cnt_inc_i = '0;
    cnt_allones_i = '0;
    lcofip_set_i = 1'b0;
    lcofip_clr_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    priv_lvl_i = 2'd3;
    debug_mode_i = 1'b0;
    csr_idx_i = '0;
    csr_wdata_i = '0;
    mcounteren_i = '1;
    idle();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    checks++;
    if (of_o !== '0) begin errors++; $display("[TB] FAIL reset_of: got %h expected 0", of_o); end
    checks++;
    if (lcofip_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_lcofip: got %b expected 0", lcofip_o); end
    checks++;
    if (count_en_o !== '1) begin errors++; $display("[TB] FAIL reset_count_en: got %h expected all ones", count_en_o); end
    checks++;
    if (scountovf_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_scountovf: got %h expected 0", scountovf_o); end
    for (int i = 0; i < 32; i++) begin
      csr_idx_i = 5'(i);
      #1;
      checks++;
      if (csr_rdata_o !== 4'b0000) begin
        errors++; $display("[TB] FAIL reset_rdata idx %0d: got %b expected 0000", i, csr_rdata_o);
      end
    end
  endtask

  task automatic test_filter();
    priv_lvl_i = 2'd3;
    csr_we_i = 1'b1; csr_idx_i = 5'd2; csr_wdata_i = 4'b0100;
    #1;
    checks++;
    if (count_en_o[2] !== 1'b1) begin errors++; $display("[TB] FAIL filter_before_edge: got %b expected 1", count_en_o[2]); end
    step(); idle();
    checks++;
    if (count_en_o[2] !== 1'b0) begin errors++; $display("[TB] FAIL filter_minh_m: got %b expected 0", count_en_o[2]); end
    checks++;
    if (count_en_o !== exp_count_en()) begin errors++; $display("[TB] FAIL filter_vec_m: got %h expected %h", count_en_o, exp_count_en()); end
    checks++;
    if (csr_rdata_o !== 4'b0100) begin errors++; $display("[TB] FAIL filter_rdata: got %b expected 0100", csr_rdata_o); end
    priv_lvl_i = 2'd1; #1;
    checks++;
    if (count_en_o !== '1) begin errors++; $display("[TB] FAIL filter_minh_s: got %h expected all ones", count_en_o); end
    debug_mode_i = 1'b1; #1;
    checks++;
    if (count_en_o !== '0) begin errors++; $display("[TB] FAIL filter_debug: got %h expected 0", count_en_o); end
    debug_mode_i = 1'b0;
    csr_we_i = 1'b1; csr_idx_i = 5'd3; csr_wdata_i = 4'b0111;
    step(); idle();
    priv_lvl_i = 2'd2; #1;
    checks++;
    if (count_en_o !== '1) begin errors++; $display("[TB] FAIL filter_priv2: got %h expected all ones", count_en_o); end
    priv_lvl_i = 2'd0; #1;
    checks++;
    if (count_en_o[3] !== 1'b0 || count_en_o[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL filter_uinh: got %b%b expected 01", count_en_o[3], count_en_o[2]);
    end
    priv_lvl_i = 2'd3;
  endtask

  task automatic test_wrap();
    cnt_inc_i[5] = 1'b1; cnt_allones_i[5] = 1'b1;
    step(); idle();
    checks++;
    if (of_o[5] !== 1'b1 || lcofip_o !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_of_lcofip: got of5=%b lcofip=%b expected 1 1", of_o[5], lcofip_o);
    end
    checks++;
    if (of_o !== m_of) begin errors++; $display("[TB] FAIL wrap_of_vec: got %h expected %h", of_o, m_of); end
    mcounteren_i = 32'h0000_0100; #1;
    checks++;
    if (scountovf_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL scountovf_set: got %h expected 00000100", scountovf_o); end
    mcounteren_i = 32'hFFFF_FEFF; #1;
    checks++;
    if (scountovf_o[8] !== 1'b0) begin errors++; $display("[TB] FAIL scountovf_mask: got %b expected 0", scountovf_o[8]); end
    mcounteren_i = '1;
  endtask

  task automatic test_lcofip_rules();
    lcofip_clr_i = 1'b1;
    step(); idle();
    checks++;
    if (lcofip_o !== 1'b0) begin errors++; $display("[TB] FAIL lcofip_clear: got %b expected 0", lcofip_o); end
    cnt_inc_i[5] = 1'b1; cnt_allones_i[5] = 1'b1;
    step(); idle();
    checks++;
    if (lcofip_o !== 1'b0 || of_o[5] !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_of_already_set: got lcofip=%b of5=%b expected 0 1", lcofip_o, of_o[5]);
    end
    csr_we_i = 1'b1; csr_idx_i = 5'd5; csr_wdata_i = 4'b0000;
    step(); idle();
    checks++;
    if (of_o[5] !== 1'b0) begin errors++; $display("[TB] FAIL sw_clear_of: got %b expected 0", of_o[5]); end
    csr_we_i = 1'b1; csr_idx_i = 5'd5; csr_wdata_i = 4'b0000;
    cnt_inc_i[5] = 1'b1; cnt_allones_i[5] = 1'b1;
    step(); idle();
    checks++;
    if (of_o[5] !== 1'b1 || lcofip_o !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_beats_write: got of5=%b lcofip=%b expected 1 1", of_o[5], lcofip_o);
    end
    lcofip_clr_i = 1'b1;
    step(); idle();
    csr_we_i = 1'b1; csr_idx_i = 5'd10; csr_wdata_i = 4'b1000;
    step(); idle();
    checks++;
    if (of_o[10] !== 1'b1 || lcofip_o !== 1'b0) begin
      errors++; $display("[TB] FAIL sw_of_no_irq: got of10=%b lcofip=%b expected 1 0", of_o[10], lcofip_o);
    end
    lcofip_set_i = 1'b1; lcofip_clr_i = 1'b1;
    step(); idle();
    checks++;
    if (lcofip_o !== 1'b1) begin errors++; $display("[TB] FAIL set_beats_clr: got %b expected 1", lcofip_o); end
  endtask

  task automatic test_multi_wrap();
    lcofip_clr_i = 1'b1;
    step(); idle();
    cnt_inc_i[0] = 1'b1; cnt_allones_i[0] = 1'b1;
    cnt_inc_i[28] = 1'b1; cnt_allones_i[28] = 1'b1;
    cnt_inc_i[7] = 1'b1;
    lcofip_clr_i = 1'b1;
    step(); idle();
    checks++;
    if (of_o[0] !== 1'b1 || of_o[28] !== 1'b1 || of_o[7] !== 1'b0 || lcofip_o !== 1'b1) begin
      errors++; $display("[TB] FAIL multi_wrap: got of0=%b of28=%b of7=%b lcofip=%b expected 1 1 0 1",
                         of_o[0], of_o[28], of_o[7], lcofip_o);
    end
  endtask

  task automatic test_invalid_idx();
    for (int i = N; i < 32; i++) begin
      csr_we_i = 1'b1; csr_idx_i = 5'(i); csr_wdata_i = 4'b1111;
      step(); idle();
      checks++;
      if (csr_rdata_o !== 4'b0000) begin errors++; $display("[TB] FAIL invalid_rdata idx %0d: got %b expected 0000", i, csr_rdata_o); end
      checks++;
      if (of_o !== m_of) begin errors++; $display("[TB] FAIL invalid_write idx %0d: got %h expected %h", i, of_o, m_of); end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      priv_lvl_i    = 2'($urandom_range(0, 3));
      debug_mode_i  = ($urandom_range(0, 7) == 0);
      csr_we_i      = ($urandom_range(0, 2) == 0);
      csr_idx_i     = 5'($urandom_range(0, 31));
      csr_wdata_i   = 4'($urandom);
      cnt_inc_i     = N'($urandom);
      cnt_allones_i = N'($urandom & $urandom & $urandom);
      mcounteren_i  = $urandom;
      lcofip_set_i  = ($urandom_range(0, 15) == 0);
      lcofip_clr_i  = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (count_en_o !== exp_count_en()) begin
        errors++; bad++; $display("[TB] FAIL rand_count_en cyc %0d: got %h expected %h", c, count_en_o, exp_count_en());
      end
      checks++;
      if (csr_rdata_o !== exp_rdata()) begin
        errors++; bad++; $display("[TB] FAIL rand_rdata cyc %0d: got %b expected %b", c, csr_rdata_o, exp_rdata());
      end
      checks++;
      if (scountovf_o !== exp_scountovf()) begin
        errors++; bad++; $display("[TB] FAIL rand_scountovf cyc %0d: got %h expected %h", c, scountovf_o, exp_scountovf());
      end
      step();
      checks++;
      if (of_o !== m_of || lcofip_o !== m_lcofip) begin
        errors++; bad++; $display("[TB] FAIL rand_state cyc %0d: got of=%h lcofip=%b expected of=%h lcofip=%b",
                                  c, of_o, lcofip_o, m_of, m_lcofip);
      end
      if (bad > 20) break;
    end
    idle();
    debug_mode_i = 1'b0;
  endtask

  task automatic test_async_reset();
    priv_lvl_i = 2'd3;
    csr_we_i = 1'b1; csr_idx_i = 5'd1; csr_wdata_i = 4'b1111;
    cnt_inc_i[4] = 1'b1; cnt_allones_i[4] = 1'b1;
    step(); idle();
    checks++;
    if (count_en_o[1] !== 1'b0 || of_o[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_state: got en1=%b of1=%b expected 0 1", count_en_o[1], of_o[1]);
    end
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    checks++;
    if (of_o !== '0 || lcofip_o !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_state: got of=%h lcofip=%b expected 0 0", of_o, lcofip_o);
    end
    checks++;
    if (count_en_o !== '1) begin errors++; $display("[TB] FAIL async_reset_count_en: got %h expected all ones", count_en_o); end
    checks++;
    if (csr_rdata_o !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset_rdata: got %b expected 0000", csr_rdata_o); end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting hpm_ovf_filter bench");
    test_reset();
    test_filter();
    test_wrap();
    test_lcofip_rules();
    test_multi_wrap();
    test_invalid_idx();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
